instr_prefetch: RTL

//  Parametrised instruction fetch unit for the pifive core. It issues sequential reads on a pipelined Wishbone

---
 rtl/instr_prefetch.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/instr_prefetch.sv
// instr_prefetch: sequential instruction fetch over a pipelined Wishbone master with a DEPTH-entry {pc, instr, err} FIFO.
// Define PREFETCH_STATS_EN to add the o_stat_fetched / o_stat_dropped statistics counters.
module instr_prefetch #(
    parameter logic [31:0] INIT_PC         = 32'h1000_0000,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [31:0] o_wb_adr,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_dat,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_err
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0] o_stat_fetched,
    output logic [31:0] o_stat_dropped
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 65;

    // Architectural state
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic halted_q, halted_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [EW-1:0] fifo_mem_q [DEPTH];

    logic [31:0] redirect_pc_c;
    logic [CW:0] credit_used_c;
    logic resp_c;
    logic push_c;
    logic pop_c;
    logic stb_c;
    logic accept_c;
    logic [EW-1:0] head_c;
    logic unused_ok;

    assign unused_ok = ^i_redirect_pc[1:0];

    // Request issue and response classification
    always_comb begin
        redirect_pc_c = {i_redirect_pc[31:2], 2'b00};
        credit_used_c = {1'b0, count_q} + {1'b0, outstanding_q};
        resp_c        = (i_wb_ack | i_wb_err) & (outstanding_q != '0);
        push_c        = resp_c & (drop_q == '0) & ~i_redirect;
        pop_c         = o_valid & i_ready & ~i_redirect;
        stb_c         = ~i_rst & ~halted_q & ~i_redirect
                        & (outstanding_q < CW'(MAX_OUTSTANDING))
                        & (credit_used_c < (CW + 1)'(DEPTH));
        accept_c      = stb_c & ~i_wb_stall;
    end

    // Next-state logic
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q + CW'(accept_c) - CW'(resp_c);
        drop_d        = drop_q;
        halted_d      = halted_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (accept_c) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (push_c) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + AW'(1);
            if (i_wb_err) begin
                halted_d = 1'b1;
            end
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_c) - CW'(pop_c);
        if (resp_c && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end

        // Redirect: flush, restart, and mark every read still in flight as stale
        if (i_redirect) begin
            fetch_pc_d = redirect_pc_c;
            resp_pc_d  = redirect_pc_c;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            halted_d   = 1'b0;
            drop_d     = outstanding_q - CW'(resp_c);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_q    <= INIT_PC;
            resp_pc_q     <= INIT_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            halted_q      <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            halted_q      <= halted_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // FIFO storage needs no reset; contents are qualified by count_q
    always_ff @(posedge i_clk) begin
        if (push_c) begin
            fifo_mem_q[wr_ptr_q] <= {resp_pc_q, i_wb_dat, i_wb_err};
        end
    end

    assign head_c   = fifo_mem_q[rd_ptr_q];
    assign o_valid  = (count_q != '0);
    assign o_pc     = head_c[64:33];
    assign o_instr  = head_c[32:1];
    assign o_err    = head_c[0];
    assign o_wb_stb = stb_c;
    assign o_wb_adr = fetch_pc_q;
    assign o_wb_cyc = stb_c | (outstanding_q != '0);

`ifdef PREFETCH_STATS_EN
    logic [31:0] stat_fetched_q, stat_fetched_d;
    logic [31:0] stat_dropped_q, stat_dropped_d;

    // Dropped = discarded responses plus entries flushed by a redirect
    always_comb begin
        stat_fetched_d = stat_fetched_q + 32'(push_c);
        stat_dropped_d = stat_dropped_q + 32'(resp_c & ~push_c);
        if (i_redirect) begin
            stat_dropped_d = stat_dropped_d + 32'(count_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stat_fetched_q <= '0;
            stat_dropped_q <= '0;
        end else begin
            stat_fetched_q <= stat_fetched_d;
            stat_dropped_q <= stat_dropped_d;
        end
    end

    assign o_stat_fetched = stat_fetched_q;
    assign o_stat_dropped = stat_dropped_q;
`endif

    // The credit rule must keep pushes away from a full FIFO
    assert property (@(posedge i_clk) disable iff (i_rst) !(push_c && (count_q == CW'(DEPTH))));

endmodule
